// File: rtl/game_event_dispatcher_pkg.sv
// Shared definitions for the game event dispatcher.
// Contents: the user event encoding shared with the user-input block and the
// game core, the level width, default gravity period constants, the dispatcher
// state type, and a helper that decides whether a popped event is forwarded.
package game_event_dispatcher_pkg;

  localparam int LEVEL_W = 4;

  // Default gravity timing, in main_logic_clk cycles.
  localparam int unsigned DEF_GRAVITY_BASE_TICKS = 32'd25_000_000;
  localparam int unsigned DEF_GRAVITY_STEP_TICKS = 32'd1_500_000;
  localparam int unsigned DEF_GRAVITY_MIN_TICKS  = 32'd2_500_000;
  localparam int          DEF_GRAVITY_CNT_W      = 32;

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_LEFT     = 3'd1,
    EV_RIGHT    = 3'd2,
    EV_ROTATE   = 3'd3,
    EV_DOWN     = 3'd4,
    EV_NEW_GAME = 3'd5
  } user_event_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } disp_state_t;

  // Outside a running game only EV_NEW_GAME gets through; EV_NONE never does.
  function automatic logic event_forwardable(input user_event_t ev, input logic active);
    event_forwardable = (ev != EV_NONE) && (active || (ev == EV_NEW_GAME));
  endfunction

endpackage

// File: rtl/game_event_dispatcher_gravity_timer.sv
// Gravity timer: derives the fall period from the level, counts clocks while a
// game is running and raises a pending-gravity flag each time the period
// expires. A second expiry while the flag is still set marks a sticky overrun.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   active           game running; when low the counter and pending flag clear
//   level            current level, shortens the period
//   take             dispatcher consumes the pending gravity event this cycle
//   clear_cnt        restart the fall timer (soft drop or new game)
//   clear_overrun    clear the sticky overrun flag (new game)
//   pend             gravity event pending
//   overrun          sticky: gravity expired while one was still pending
module game_event_dispatcher_gravity_timer
  import game_event_dispatcher_pkg::*;
#(
  parameter int unsigned GRAVITY_BASE_TICKS = DEF_GRAVITY_BASE_TICKS,
  parameter int unsigned GRAVITY_STEP_TICKS = DEF_GRAVITY_STEP_TICKS,
  parameter int unsigned GRAVITY_MIN_TICKS  = DEF_GRAVITY_MIN_TICKS,
  parameter int          CNT_W              = DEF_GRAVITY_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               active,
  input  logic [LEVEL_W-1:0] level,
  input  logic               take,
  input  logic               clear_cnt,
  input  logic               clear_overrun,
  output logic               pend,
  output logic               overrun
);

  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(GRAVITY_BASE_TICKS);
  localparam logic [CNT_W-1:0] STEP_C = CNT_W'(GRAVITY_STEP_TICKS);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(GRAVITY_MIN_TICKS);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1'b1);

  logic [CNT_W-1:0] count_r;
  logic             pend_r;
  logic             overrun_r;
  logic [CNT_W-1:0] reduction_s;
  logic [CNT_W-1:0] period_s;
  logic             expire_s;

  // Period from level, clamped to the floor before the subtraction can wrap.
  // The compare uses >= so a level change that shortens the period below the
  // current count expires on the very next cycle instead of running to wrap.
  always_comb begin
    reduction_s = CNT_W'(level) * STEP_C;
    if (reduction_s >= BASE_C) begin
      period_s = MIN_C;
    end else if ((BASE_C - reduction_s) < MIN_C) begin
      period_s = MIN_C;
    end else begin
      period_s = BASE_C - reduction_s;
    end
    expire_s = (count_r >= (period_s - ONE_C));
  end

  // Counter and pending flag; a clear in the same cycle as an expiry wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {CNT_W{1'b0}};
      pend_r  <= 1'b0;
    end else if (!active || clear_cnt) begin
      count_r <= {CNT_W{1'b0}};
      pend_r  <= 1'b0;
    end else if (expire_s) begin
      count_r <= {CNT_W{1'b0}};
      pend_r  <= 1'b1;
    end else begin
      count_r <= count_r + ONE_C;
      pend_r  <= pend_r & ~take;
    end
  end

  // Sticky overrun: expiry while the previous gravity event is still unconsumed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun_r <= 1'b0;
    end else if (clear_overrun) begin
      overrun_r <= 1'b0;
    end else if (active && !clear_cnt && expire_s && pend_r && !take) begin
      overrun_r <= 1'b1;
    end
  end

  assign pend    = pend_r;
  assign overrun = overrun_r;

endmodule

// File: rtl/game_event_dispatcher.sv
// Game event dispatcher: pops debounced button events from the user-input
// block, merges them with periodic gravity EV_DOWN and presents one command at
// a time to the game core over a valid/ready handshake.
// Ports:
//   main_logic_clk_i, rst_n_i   clock, asynchronous active-low reset
//   user_event_i                head event of the user-input block
//   user_event_ready_i          head event available
//   user_event_rd_req_o         one-cycle pop of the head event
//   game_active_i               game core is running a game
//   level_i                     current level
//   cmd_o, cmd_from_gravity_o   command and its origin
//   cmd_valid_o, cmd_ready_i    command handshake
//   gravity_overrun_o           sticky gravity overrun flag
module game_event_dispatcher
  import game_event_dispatcher_pkg::*;
#(
  parameter int unsigned GRAVITY_BASE_TICKS = DEF_GRAVITY_BASE_TICKS,
  parameter int unsigned GRAVITY_STEP_TICKS = DEF_GRAVITY_STEP_TICKS,
  parameter int unsigned GRAVITY_MIN_TICKS  = DEF_GRAVITY_MIN_TICKS,
  parameter int          CNT_W              = DEF_GRAVITY_CNT_W
) (
  input  logic               main_logic_clk_i,
  input  logic               rst_n_i,
  input  user_event_t        user_event_i,
  input  logic               user_event_ready_i,
  output logic               user_event_rd_req_o,
  input  logic               game_active_i,
  input  logic [LEVEL_W-1:0] level_i,
  output user_event_t        cmd_o,
  output logic               cmd_from_gravity_o,
  output logic               cmd_valid_o,
  input  logic               cmd_ready_i,
  output logic               gravity_overrun_o
);

  disp_state_t state_r;
  user_event_t cmd_r;
  logic        from_gravity_r;
  logic        valid_r;

  logic        pend_s;
  logic        overrun_s;
  logic        take_s;
  logic        pop_s;
  logic        fwd_s;
  logic        clear_cnt_s;
  logic        clear_overrun_s;

  // Per-cycle decision in IDLE: pending gravity beats a waiting user event.
  // The pop is decoded combinationally so the request lands in the same cycle
  // the head is sampled; it is gated by reset so nothing is popped while held.
  always_comb begin
    take_s = 1'b0;
    pop_s  = 1'b0;
    fwd_s  = 1'b0;
    if (rst_n_i && (state_r == ST_IDLE)) begin
      if (pend_s) begin
        take_s = 1'b1;
      end else if (user_event_ready_i) begin
        pop_s = 1'b1;
        fwd_s = event_forwardable(user_event_i, game_active_i);
      end else begin
        pop_s = 1'b0;
      end
    end else begin
      take_s = 1'b0;
    end
    clear_cnt_s     = fwd_s && ((user_event_i == EV_DOWN) || (user_event_i == EV_NEW_GAME));
    clear_overrun_s = fwd_s && (user_event_i == EV_NEW_GAME);
  end

  game_event_dispatcher_gravity_timer #(
    .GRAVITY_BASE_TICKS (GRAVITY_BASE_TICKS),
    .GRAVITY_STEP_TICKS (GRAVITY_STEP_TICKS),
    .GRAVITY_MIN_TICKS  (GRAVITY_MIN_TICKS),
    .CNT_W              (CNT_W)
  ) u_gravity_timer (
    .clk           (main_logic_clk_i),
    .rst_n         (rst_n_i),
    .active        (game_active_i),
    .level         (level_i),
    .take          (take_s),
    .clear_cnt     (clear_cnt_s),
    .clear_overrun (clear_overrun_s),
    .pend          (pend_s),
    .overrun       (overrun_s)
  );

  // Dispatcher FSM with registered command outputs held stable during ISSUE.
  always_ff @(posedge main_logic_clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_r        <= ST_IDLE;
      cmd_r          <= EV_NONE;
      from_gravity_r <= 1'b0;
      valid_r        <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (take_s) begin
            cmd_r          <= EV_DOWN;
            from_gravity_r <= 1'b1;
            valid_r        <= 1'b1;
            state_r        <= ST_ISSUE;
          end else if (fwd_s) begin
            cmd_r          <= user_event_i;
            from_gravity_r <= 1'b0;
            valid_r        <= 1'b1;
            state_r        <= ST_ISSUE;
          end else begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (cmd_ready_i) begin
            valid_r <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            valid_r <= 1'b1;
            state_r <= ST_ISSUE;
          end
        end
        default: begin
          valid_r <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign user_event_rd_req_o = pop_s;
  assign cmd_o               = cmd_r;
  assign cmd_from_gravity_o  = from_gravity_r;
  assign cmd_valid_o         = valid_r;
  assign gravity_overrun_o   = overrun_s;

endmodule

// File: tb/tb_game_event_dispatcher.sv
module tb_game_event_dispatcher;
  import game_event_dispatcher_pkg::*;

  typedef struct {
    user_event_t cmd;
    logic        grav;
    int          cyc;
  } exp_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  user_event_t        ev = EV_NONE;
  logic               ev_ready = 1'b0;
  logic               rd_req;
  logic               active = 1'b0;
  logic [LEVEL_W-1:0] level = 4'd0;
  user_event_t        cmd;
  logic               grav;
  logic               valid;
  logic               cmd_ready = 1'b0;
  logic               overrun;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  exp_t q[$];

  game_event_dispatcher #(
    .GRAVITY_BASE_TICKS (10),
    .GRAVITY_STEP_TICKS (2),
    .GRAVITY_MIN_TICKS  (4),
    .CNT_W              (32)
  ) dut (
    .main_logic_clk_i    (clk),
    .rst_n_i             (rst_n),
    .user_event_i        (ev),
    .user_event_ready_i  (ev_ready),
    .user_event_rd_req_o (rd_req),
    .game_active_i       (active),
    .level_i             (level),
    .cmd_o               (cmd),
    .cmd_from_gravity_o  (grav),
    .cmd_valid_o         (valid),
    .cmd_ready_i         (cmd_ready),
    .gravity_overrun_o   (overrun)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_exp(input user_event_t c, input logic g, input int t);
    exp_t e;
    e.cmd  = c;
    e.grav = g;
    e.cyc  = t;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int t);
    while (cyc < t) tick();
  endtask

  // Monitor: compare each accepted command with the scoreboard head, and
  // check that a back-pressured command is held stable.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (q.size() == 0) begin
        chk("unexpected_cmd", int'(cmd), -1);
      end else if (cmd_ready) begin
        exp_t e;
        e = q.pop_front();
        chk("cmd_value", int'(cmd), int'(e.cmd));
        chk("cmd_from_gravity", int'(grav), int'(e.grav));
        if (e.cyc >= 0) chk("cmd_cycle", cyc, e.cyc);
      end else begin
        chk("cmd_held", int'(cmd), int'(q[0].cmd));
        chk("grav_held", int'(grav), int'(q[0].grav));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    int pops;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_cmd", int'(cmd), int'(EV_NONE));
    chk("rst_grav", int'(grav), 0);
    chk("rst_overrun", int'(overrun), 0);
    tick();
    rst_n = 1'b1;

    // Pop handshake
    tick();
    active = 1'b1;
    tick();
    c = cyc;
    ev = EV_LEFT; ev_ready = 1'b1; cmd_ready = 1'b1;
    push_exp(EV_LEFT, 1'b0, c + 1);
    @(negedge clk); chk("pop_pulse", int'(rd_req), 1);
    tick();
    ev = EV_NONE; ev_ready = 1'b0;
    @(negedge clk); chk("pop_one_cycle", int'(rd_req), 0);
    tick();
    @(negedge clk); chk("valid_drop", int'(valid), 0);
    tick();
    active = 1'b0;

    // Backpressure, then first gravity at level 0
    tick();
    c = cyc;
    active = 1'b1; cmd_ready = 1'b0;
    ev = EV_ROTATE; ev_ready = 1'b1;
    push_exp(EV_ROTATE, 1'b0, c + 6);
    push_exp(EV_RIGHT, 1'b0, c + 8);
    push_exp(EV_DOWN, 1'b1, c + 11);
    @(negedge clk); chk("bp_first_pop", int'(rd_req), 1);
    pops = 0;
    tick();
    ev = EV_RIGHT;
    for (int i = 1; i <= 6; i++) begin
      if (i == 6) cmd_ready = 1'b1;
      @(negedge clk);
      if (rd_req) pops++;
      if (i < 6) tick();
    end
    chk("bp_no_pop_in_issue", pops, 0);
    tick();
    @(negedge clk); chk("bp_pop_after_accept", int'(rd_req), 1);
    tick();
    ev = EV_NONE; ev_ready = 1'b0;
    wait_until(c + 12);
    active = 1'b0;

    // Gravity timing: period 10, then level 5 saturates to 4
    tick();
    c = cyc;
    active = 1'b1;
    push_exp(EV_DOWN, 1'b1, c + 11);
    push_exp(EV_DOWN, 1'b1, c + 21);
    push_exp(EV_DOWN, 1'b1, c + 25);
    push_exp(EV_DOWN, 1'b1, c + 29);
    wait_until(c + 22);
    level = 4'd5;
    wait_until(c + 30);
    active = 1'b0;

    // Gravity priority and overrun under backpressure
    tick();
    c = cyc;
    active = 1'b1; cmd_ready = 1'b0;
    push_exp(EV_DOWN, 1'b1, c + 16);
    push_exp(EV_DOWN, 1'b1, c + 18);
    push_exp(EV_LEFT, 1'b0, c + 20);
    push_exp(EV_DOWN, 1'b1, c + 22);
    wait_until(c + 4);
    ev = EV_LEFT; ev_ready = 1'b1;
    @(negedge clk); chk("gravity_beats_user", int'(rd_req), 0);
    wait_until(c + 10);
    @(negedge clk); chk("overrun_not_yet", int'(overrun), 0);
    wait_until(c + 12);
    @(negedge clk); chk("overrun_set", int'(overrun), 1);
    wait_until(c + 16);
    cmd_ready = 1'b1;
    wait_until(c + 20);
    ev = EV_NONE; ev_ready = 1'b0;
    wait_until(c + 23);
    active = 1'b0;
    tick();
    @(negedge clk); chk("overrun_sticky", int'(overrun), 1);

    // Inactive filtering: EV_LEFT dropped, EV_NEW_GAME issued
    tick();
    c = cyc;
    ev = EV_LEFT; ev_ready = 1'b1;
    @(negedge clk); chk("inactive_pop_left", int'(rd_req), 1);
    tick();
    ev = EV_NEW_GAME;
    push_exp(EV_NEW_GAME, 1'b0, c + 2);
    @(negedge clk); chk("inactive_pop_new_game", int'(rd_req), 1);
    tick();
    ev = EV_NONE; ev_ready = 1'b0;
    @(negedge clk); chk("overrun_cleared", int'(overrun), 0);
    wait_until(c + 15);

    // Soft drop restarts the fall timer
    tick();
    c = cyc;
    active = 1'b1; level = 4'd0;
    push_exp(EV_DOWN, 1'b0, c + 8);
    push_exp(EV_DOWN, 1'b1, c + 19);
    wait_until(c + 7);
    ev = EV_DOWN; ev_ready = 1'b1;
    tick();
    ev = EV_NONE; ev_ready = 1'b0;
    wait_until(c + 20);

    // Asynchronous reset while a command is held
    ev = EV_ROTATE; ev_ready = 1'b1; cmd_ready = 1'b0;
    push_exp(EV_ROTATE, 1'b0, -1);
    tick();
    ev = EV_NONE; ev_ready = 1'b0;
    tick();
    ev = EV_LEFT; ev_ready = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(valid), 0);
    chk("async_rst_cmd", int'(cmd), int'(EV_NONE));
    chk("async_rst_grav", int'(grav), 0);
    chk("async_rst_no_pop", int'(rd_req), 0);
    q.delete();
    tick();
    tick();
    ev = EV_NONE; ev_ready = 1'b0; active = 1'b0;
    rst_n = 1'b1;
    tick();
    tick();
    @(negedge clk); chk("post_reset_idle", int'(valid), 0);
    chk("scoreboard_drained", q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
